// File: rtl/mas_vedic_pp_combiner_seq_if.sv
// mas_vedic_pp_combiner_seq_if: partial-product input / product output handshake bundle (pp_err present with MAS_PP_CHECK_EN)
interface mas_vedic_pp_combiner_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pp_ll;
    logic [15:0] pp_lh;
    logic [15:0] pp_hl;
    logic [15:0] pp_hh;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
`ifdef MAS_PP_CHECK_EN
    logic        pp_err;
    modport master (
        output in_valid, pp_ll, pp_lh, pp_hl, pp_hh, out_ready,
        input  in_ready, out_valid, res, pp_err
    );
    modport slave (
        input  in_valid, pp_ll, pp_lh, pp_hl, pp_hh, out_ready,
        output in_ready, out_valid, res, pp_err
    );
`else
    modport master (
        output in_valid, pp_ll, pp_lh, pp_hl, pp_hh, out_ready,
        input  in_ready, out_valid, res
    );
    modport slave (
        input  in_valid, pp_ll, pp_lh, pp_hl, pp_hh, out_ready,
        output in_ready, out_valid, res
    );
`endif
endinterface

// File: rtl/mas_vedic_pp_combiner_seq.sv
// mas_vedic_pp_combiner_seq: combines four 8x8 partial products into a 16x16 product over three cycles of one shared 16-bit adder; MAS_PP_CHECK_EN adds a sticky pp_err flag.
module mas_vedic_pp_combiner_seq (
    input logic clk,
    input logic rst,
    mas_vedic_pp_combiner_seq_if.slave io
);
    typedef enum logic [2:0] {IDLE, S_MID, S_LO, S_HI, DONE} state_t;
    state_t state, state_nx;
    logic [15:0] ll, lh, hl, hh, mid, add_a, add_b, sum;
    logic [7:0] s2_hi;
    logic [31:0] res;
    logic c1, c2, co, xfer;
    assign xfer = io.in_valid && state == IDLE;
    assign io.res = res;
    // Operand select for the single shared adder: mid sum, low fold, then high word
    always_comb begin
        add_a = state == S_MID ? lh : state == S_LO ? mid : hh;
        add_b = state == S_MID ? hl : state == S_LO ? {8'h00, ll[15:8]} : {7'b0, c1 | c2, s2_hi};
        {co, sum} = {1'b0, add_a} + {1'b0, add_b};
    end
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // Next-state: fixed walk through the three add cycles, hold in DONE until consumed
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = io.in_valid ? S_MID : IDLE;
            S_MID:   state_nx = S_LO;
            S_LO:    state_nx = S_HI;
            S_HI:    state_nx = DONE;
            DONE:    state_nx = io.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // Handshake outputs decoded from state
    always_comb begin
        io.in_ready = state == IDLE;
        io.out_valid = state == DONE;
    end
    // Datapath: capture the set, then accumulate carries and result slices
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ll <= '0;
            lh <= '0;
            hl <= '0;
            hh <= '0;
            mid <= '0;
            s2_hi <= '0;
            c1 <= 1'b0;
            c2 <= 1'b0;
            res <= '0;
        end else begin
            if (xfer) begin
                ll <= io.pp_ll;
                lh <= io.pp_lh;
                hl <= io.pp_hl;
                hh <= io.pp_hh;
            end
            if (state == S_MID) begin
                mid <= sum;
                c1 <= co;
            end
            if (state == S_LO) begin
                c2 <= co;
                s2_hi <= sum[15:8];
                res[15:0] <= {sum[7:0], ll[7:0]};
            end
            if (state == S_HI) res[31:16] <= sum;
        end
    end
`ifdef MAS_PP_CHECK_EN
    logic pp_err;
    assign io.pp_err = pp_err;
    // Sticky flag: out-of-range partial product on capture, or overflow of the high word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pp_err <= 1'b0;
        else if ((xfer && (io.pp_ll > 16'hFE01 || io.pp_lh > 16'hFE01 || io.pp_hl > 16'hFE01 || io.pp_hh > 16'hFE01)) || (state == S_HI && co)) pp_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_mas_vedic_pp_combiner_seq.sv
// tb_mas_vedic_pp_combiner_seq: directed self-checking bench for the partial-product combiner.
module tb_mas_vedic_pp_combiner_seq;
    typedef struct packed {
        logic [15:0] ll;
        logic [15:0] lh;
        logic [15:0] hl;
        logic [15:0] hh;
        logic [31:0] r;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    vec_t vecs [7];

    mas_vedic_pp_combiner_seq_if bus();
    mas_vedic_pp_combiner_seq dut (.clk(clk), .rst(rst), .io(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input vec_t v);
        bus.pp_ll = v.ll;
        bus.pp_lh = v.lh;
        bus.pp_hl = v.hl;
        bus.pp_hh = v.hh;
    endtask

    // present one set; returns #1 after the transfer edge
    task automatic send(input vec_t v);
        drive(v);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // edges counted from and including the transfer edge until out_valid; -1 on timeout
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!bus.out_valid) edges = -1;
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++;
        if (bus.res !== 32'h0) begin n_err++; $display("FAIL reset_res: got %h expected 00000000", bus.res); end
`ifdef MAS_PP_CHECK_EN
        n_cmp++;
        if (bus.pp_err !== 1'b0) begin n_err++; $display("FAIL reset_pp_err: got %b expected 0", bus.pp_err); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_products();
        int e;
        for (int i = 0; i < 7; i++) begin
            send(vecs[i]);
            wait_valid(e);
            n_cmp++;
            if (e !== 4) begin n_err++; $display("FAIL latency[%0d]: got %0d edges expected 4", i, e); end
            n_cmp++;
            if (bus.res !== vecs[i].r) begin n_err++; $display("FAIL res[%0d]: got %h expected %h", i, bus.res, vecs[i].r); end
            accept();
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL release[%0d]: got out_valid=%b in_ready=%b expected 0/1", i, bus.out_valid, bus.in_ready); end
            n_cmp++;
            if (bus.res !== vecs[i].r) begin n_err++; $display("FAIL idle_hold[%0d]: got %h expected %h", i, bus.res, vecs[i].r); end
        end
    endtask

    task automatic test_stall();
        int e;
        send(vecs[0]);
        wait_valid(e);
        n_cmp++;
        if (e !== 4) begin n_err++; $display("FAIL stall_latency: got %0d edges expected 4", e); end
        drive(vecs[2]);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.res !== 32'h06260060) begin
                n_err++;
                $display("FAIL stall[%0d]: got out_valid=%b in_ready=%b res=%h expected 1/0/06260060", k, bus.out_valid, bus.in_ready, bus.res);
            end
        end
        bus.in_valid = 1'b0;
        accept();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.res !== 32'h06260060) begin n_err++; $display("FAIL stall_release: got in_ready=%b res=%h expected 1/06260060", bus.in_ready, bus.res); end
    endtask

    task automatic test_reset_mid();
        int e;
        send(vecs[1]);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.res !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid: got out_valid=%b in_ready=%b res=%h expected 0/1/00000000", bus.out_valid, bus.in_ready, bus.res);
        end
        #2;
        rst = 1'b0;
        send(vecs[2]);
        wait_valid(e);
        n_cmp++;
        if (e !== 4) begin n_err++; $display("FAIL post_reset_latency: got %0d edges expected 4", e); end
        n_cmp++;
        if (bus.res !== 32'h00030A08) begin n_err++; $display("FAIL post_reset_res: got %h expected 00030a08", bus.res); end
        accept();
    endtask

    task automatic test_back_to_back();
        int e;
        int t [3];
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(vecs[i + 3]);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            t[i] = cyc;
            bus.in_valid = 1'b0;
            wait_valid(e);
            n_cmp++;
            if (bus.res !== vecs[i + 3].r) begin n_err++; $display("FAIL b2b_res[%0d]: got %h expected %h", i, bus.res, vecs[i + 3].r); end
            if (i > 0) begin
                n_cmp++;
                if (t[i] - t[i - 1] !== 5) begin n_err++; $display("FAIL b2b_period[%0d]: got %0d cycles expected 5", i, t[i] - t[i - 1]); end
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.in_ready); end
        end
        bus.out_ready = 1'b0;
    endtask

`ifdef MAS_PP_CHECK_EN
    task automatic test_pp_err();
        int e;
        send(vecs[1]);
        wait_valid(e);
        accept();
        n_cmp++;
        if (bus.pp_err !== 1'b0) begin n_err++; $display("FAIL pp_err_legal: got %b expected 0", bus.pp_err); end
        send(vec_t'({16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 32'hFFFF0000}));
        n_cmp++;
        if (bus.pp_err !== 1'b1) begin n_err++; $display("FAIL pp_err_set: got %b expected 1", bus.pp_err); end
        wait_valid(e);
        n_cmp++;
        if (bus.res !== 32'hFFFF0000) begin n_err++; $display("FAIL pp_err_res: got %h expected ffff0000", bus.res); end
        accept();
        send(vecs[0]);
        wait_valid(e);
        accept();
        n_cmp++;
        if (bus.pp_err !== 1'b1) begin n_err++; $display("FAIL pp_err_sticky: got %b expected 1", bus.pp_err); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.pp_err !== 1'b0) begin n_err++; $display("FAIL pp_err_clear: got %b expected 0", bus.pp_err); end
        #2;
        rst = 1'b0;
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.pp_ll = '0;
        bus.pp_lh = '0;
        bus.pp_hl = '0;
        bus.pp_hh = '0;
        vecs[0] = vec_t'({16'h1860, 16'h1178, 16'h0870, 16'h060C, 32'h06260060});
        vecs[1] = vec_t'({16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01, 32'hFFFE0001});
        vecs[2] = vec_t'({16'h0008, 16'h0006, 16'h0004, 16'h0003, 32'h00030A08});
        vecs[3] = vec_t'({16'h00FF, 16'h0000, 16'h00FF, 16'h0000, 32'h0000FFFF});
        vecs[4] = vec_t'({16'hFE01, 16'h807F, 16'h7F80, 16'h4080, 32'h4180FD01});
        vecs[5] = vec_t'({16'h0000, 16'h0000, 16'h0000, 16'h4000, 32'h40000000});
        vecs[6] = vec_t'({16'h0000, 16'h0000, 16'h0000, 16'h0000, 32'h00000000});
        test_reset();
        test_products();
        test_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef MAS_PP_CHECK_EN
        test_pp_err();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
